mem_access_unit: RTL and testbench
==================================

MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 255, meaning the maximum number of REQ-state cycles to wait for bus_ack (legal range 1..65535).
REQ-002 clk  in  1  clock; all state updates on the rising edge.
REQ-003 rst_n  in  1  reset: asynchronous, active-low.
REQ-004 memory_read, memory_write, lorD, ir_write  in  1 each  access controls from the control unit.
REQ-005 funct3  in  3  access size: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; other codes are treated as LW.
REQ-006 pc, alu_out, wdata  in  32 each  fetch address, data address, store data.
REQ-007 bus_req, bus_we  out  1 each  bus request and write enable, both registered.
REQ-008 bus_addr  out  32  word-aligned address; bus_wdata out 32; bus_wstrb out 4; all registered.
REQ-009 bus_ack  in  1; bus_rdata  in  32.
REQ-010 ir, mdr  out  32 each  instruction register and formatted load data.
REQ-011 busy  out  1  stall to the control unit; timeout_err, misalign_err  out  1 each, single-cycle pulses.

Function
REQ-012 SHALL implement the FSM states IDLE, REQ and DONE.
REQ-013 IDLE behaviour when memory_read or memory_write is high:
- latch addr = lorD ? alu_out : pc;
- latch funct3, ir_write, lorD and the direction;
- go to REQ.
REQ-014 busy SHALL be combinational: high in IDLE while a request input is high, and high throughout REQ; low in IDLE when there is no request, and low in DONE.
REQ-015 In REQ, bus_req SHALL be 1, with bus_addr = {addr[31:2],2'b00} and bus_we = latched write.
REQ-016 Stores SHALL drive bus_wstrb and bus_wdata as follows:
- SB: bus_wstrb = 0001<<addr[1:0], wdata[7:0] replicated into all four bytes;
- SH: bus_wstrb = 0011<<{addr[1],0}, wdata[15:0] replicated into both halves;
- SW: bus_wstrb = 1111, bus_wdata = wdata.
REQ-017 Reads SHALL drive bus_wstrb = 0000.
REQ-018 On a REQ cycle with bus_ack=1:
- drop bus_req at the next edge and go to DONE;
- for a read with latched ir_write=1 and lorD=0, load ir with bus_rdata unformatted;
- for any other read, load mdr with the selected byte or half, sign- or zero-extended per funct3.
REQ-019 DONE SHALL last exactly one cycle, ignore request inputs, and return to IDLE; a request held high across DONE SHALL start a new access only from IDLE.
REQ-020 Minimum latency: request seen in cycle N, ack in cycle N+1, busy low in cycle N+2.
REQ-021 A counter SHALL run in REQ. After TIMEOUT_CYCLES cycles without ack:
- drop bus_req and go to DONE;
- pulse timeout_err in DONE;
- leave ir and mdr unchanged.
REQ-022 If memory_read and memory_write are high together in IDLE, the write SHALL be performed and the read ignored.
REQ-023 An ack arriving in IDLE or DONE SHALL be ignored.

Reset
REQ-024 While rst_n=0, regardless of FSM state:
- state = IDLE;
- bus_req, bus_we, bus_addr, bus_wdata, bus_wstrb, ir, mdr, timeout_err, misalign_err and the counter SHALL be 0.
REQ-025 Reset mid-transaction SHALL drop bus_req immediately and discard any pending ack.

Configuration
REQ-026 Macro MEM_ACCESS_MISALIGN_CHECK_EN SHALL control misalignment checking.
- Defined: a halfword with addr[0]=1 or a word with addr[1:0]!=00 SHALL skip the bus, go IDLE->DONE, pulse misalign_err in DONE, and leave ir, mdr and memory unchanged.
- Undefined: misalign_err SHALL be tied to 0, a word ignores addr[1:0], and a halfword uses addr[1] only.

Verification
REQ-027 Fetch, with pc=0x100, memory_read=1, ir_write=1, lorD=0 and ack one cycle later with rdata=0x00500093 -> bus_addr=0x100, ir=0x00500093, busy low 2 cycles after the request.
REQ-028 LB, with alu_out=0x203, lorD=1 and rdata=0x80FFFFFF -> bus_addr=0x200, mdr=0xFFFFFF80; LBU with the same stimulus -> mdr=0x00000080.
REQ-029 SH, with alu_out=0x46 and wdata=0x1234ABCD -> bus_wstrb=1100, bus_wdata=0xABCDABCD, bus_we=1.
REQ-030 No ack, TIMEOUT_CYCLES=4 -> bus_req high for 4 cycles, then timeout_err pulses once and mdr is unchanged.
REQ-031 With the macro defined, LW at alu_out=0x102 -> bus_req never asserts and misalign_err pulses; with the macro undefined -> bus_addr=0x100.
REQ-032 rst_n low in REQ, with ack arriving one cycle after reset release -> bus_req=0, ir=0, mdr=0, and the ack is ignored.

Source files
------------

// File: rtl/mem_access_unit.sv
// Multicycle memory access unit: fetch/load/store bus sequencer with timeout.
// Optional MEM_ACCESS_MISALIGN_CHECK_EN rejects misaligned half/word accesses.
module mem_access_unit #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        memory_read,
  input  logic        memory_write,
  input  logic        lorD,
  input  logic        ir_write,
  input  logic [2:0]  funct3,
  input  logic [31:0] pc,
  input  logic [31:0] alu_out,
  input  logic [31:0] wdata,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  output logic [3:0]  bus_wstrb,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata,
  output logic [31:0] ir,
  output logic [31:0] mdr,
  output logic        busy,
  output logic        timeout_err,
  output logic        misalign_err
);

  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

  localparam logic [15:0] TLIM = 16'(TIMEOUT_CYCLES - 1);

  state_t      state_q;
  logic [1:0]  alo_q;
  logic [2:0]  f3_q;
  logic        irw_q;
  logic        lord_q;
  logic [15:0] cnt_q;

  logic [31:0] addr_d;
  logic        start_d;
  logic        byte_d;
  logic        half_d;
  logic        mis_d;
  logic [3:0]  strb_d;
  logic [31:0] wdat_d;
  logic [31:0] shr_d;
  logic [7:0]  b8_d;
  logic [15:0] h16_d;
  logic [31:0] ld_d;

  assign addr_d  = lorD ? alu_out : pc;
  assign start_d = memory_read | memory_write;
  assign byte_d  = (funct3[1:0] == 2'b00);
  assign half_d  = (funct3[1:0] == 2'b01);

  assign busy = (state_q == REQ) ||
                ((state_q == IDLE) && start_d);

`ifdef MEM_ACCESS_MISALIGN_CHECK_EN
  logic mis_q;
  assign mis_d = (half_d && addr_d[0]) ||
                 (!byte_d && !half_d && (addr_d[1:0] != 2'b00));
  assign misalign_err = mis_q;
`else
  assign mis_d = 1'b0;
  assign misalign_err = 1'b0;
`endif

  always_comb begin
    strb_d = 4'b1111;
    wdat_d = wdata;
    unique case (1'b1)
      byte_d: begin
        strb_d = 4'b0001 << addr_d[1:0];
        wdat_d = {4{wdata[7:0]}};
      end
      half_d: begin
        strb_d = 4'b0011 << {addr_d[1], 1'b0};
        wdat_d = {2{wdata[15:0]}};
      end
      default: begin
        strb_d = 4'b1111;
        wdat_d = wdata;
      end
    endcase
  end

  // Load formatting uses the offset and size captured at request time
  always_comb begin
    shr_d = bus_rdata >> {alo_q, 3'b000};
    b8_d  = shr_d[7:0];
    h16_d = alo_q[1] ? bus_rdata[31:16] : bus_rdata[15:0];
    case (f3_q)
      3'b000:  ld_d = {{24{b8_d[7]}}, b8_d};
      3'b100:  ld_d = {24'h0, b8_d};
      3'b001:  ld_d = {{16{h16_d[15]}}, h16_d};
      3'b101:  ld_d = {16'h0, h16_d};
      default: ld_d = bus_rdata;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      alo_q       <= '0;
      f3_q        <= '0;
      irw_q       <= 1'b0;
      lord_q      <= 1'b0;
      cnt_q       <= '0;
      bus_req     <= 1'b0;
      bus_we      <= 1'b0;
      bus_addr    <= '0;
      bus_wdata   <= '0;
      bus_wstrb   <= '0;
      ir          <= '0;
      mdr         <= '0;
      timeout_err <= 1'b0;
`ifdef MEM_ACCESS_MISALIGN_CHECK_EN
      mis_q       <= 1'b0;
`endif
    end else begin
      timeout_err <= 1'b0;
`ifdef MEM_ACCESS_MISALIGN_CHECK_EN
      mis_q       <= 1'b0;
`endif
      case (state_q)
        IDLE: begin
          if (start_d) begin
            alo_q  <= addr_d[1:0];
            f3_q   <= funct3;
            irw_q  <= ir_write;
            lord_q <= lorD;
            cnt_q  <= '0;
            if (mis_d) begin
              state_q <= DONE;
`ifdef MEM_ACCESS_MISALIGN_CHECK_EN
              mis_q   <= 1'b1;
`endif
            end else begin
              state_q   <= REQ;
              bus_req   <= 1'b1;
              bus_we    <= memory_write;
              bus_addr  <= {addr_d[31:2], 2'b00};
              bus_wstrb <= memory_write ? strb_d : 4'b0000;
              bus_wdata <= memory_write ? wdat_d : 32'h0;
            end
          end
        end
        REQ: begin
          if (bus_ack) begin
            state_q <= DONE;
            bus_req <= 1'b0;
            bus_we  <= 1'b0;
            if (!bus_we) begin
              if (irw_q && !lord_q) ir <= bus_rdata;
              else                  mdr <= ld_d;
            end
          end else if (cnt_q == TLIM) begin
            state_q     <= DONE;
            bus_req     <= 1'b0;
            bus_we      <= 1'b0;
            timeout_err <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 16'd1;
          end
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Randomized self-checking bench for mem_access_unit.
// Expectations follow MEM_ACCESS_MISALIGN_CHECK_EN the same way as the design.
module tb_mem_access_unit;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        memory_read = 1'b0;
  logic        memory_write = 1'b0;
  logic        lorD = 1'b0;
  logic        ir_write = 1'b0;
  logic [2:0]  funct3 = 3'b010;
  logic [31:0] pc = '0;
  logic [31:0] alu_out = '0;
  logic [31:0] wdata = '0;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic [3:0]  bus_wstrb;
  logic        bus_ack = 1'b0;
  logic [31:0] bus_rdata = '0;
  logic [31:0] ir;
  logic [31:0] mdr;
  logic        busy;
  logic        timeout_err;
  logic        misalign_err;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_ir = '0;
  logic [31:0] exp_mdr = '0;

  mem_access_unit #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .memory_read(memory_read), .memory_write(memory_write),
    .lorD(lorD), .ir_write(ir_write), .funct3(funct3),
    .pc(pc), .alu_out(alu_out), .wdata(wdata),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
    .bus_wdata(bus_wdata), .bus_wstrb(bus_wstrb),
    .bus_ack(bus_ack), .bus_rdata(bus_rdata),
    .ir(ir), .mdr(mdr), .busy(busy),
    .timeout_err(timeout_err), .misalign_err(misalign_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Size class: 0 byte, 1 half, 2 word
  function automatic int size_of(input logic [2:0] f3);
    int s;
    s = int'(f3) % 4;
    return (s >= 2) ? 2 : s;
  endfunction

  function automatic logic [31:0] ref_load(input logic [2:0] f3,
                                           input logic [31:0] a,
                                           input logic [31:0] rd);
    int off;
    longint unsigned v;
    off = int'(a % 4);
    if (f3 == 3'b000 || f3 == 3'b100) begin
      v = (longint'(rd) / (longint'(1) << (8 * off))) % 256;
      if (f3 == 3'b000 && v >= 128) v = v + 64'hFFFFFF00;
    end else if (f3 == 3'b001 || f3 == 3'b101) begin
      v = (off >= 2) ? longint'(rd) / 65536 : longint'(rd) % 65536;
      if (f3 == 3'b001 && v >= 32768) v = v + 64'hFFFF0000;
    end else begin
      v = longint'(rd);
    end
    return 32'(v);
  endfunction

  task automatic drop_req();
    memory_read  = 1'b0;
    memory_write = 1'b0;
  endtask

  // dly < 0 means the bus never acknowledges
  task automatic xact(input bit wr, input bit rd, input bit irw,
                      input bit lord, input logic [2:0] f3,
                      input logic [31:0] pcv, input logic [31:0] alu,
                      input logic [31:0] wd, input logic [31:0] rdv,
                      input int dly);
    logic [31:0] a;
    logic [3:0]  es;
    logic [31:0] ew;
    int sz;
    int n;
    bit mis;
    a  = lord ? alu : pcv;
    sz = size_of(f3);
    mis = 1'b0;
`ifdef MEM_ACCESS_MISALIGN_CHECK_EN
    mis = (sz == 1 && a % 2 != 0) || (sz == 2 && a % 4 != 0);
`endif
    if (sz == 0) begin
      es = 4'(1 << (a % 4));
      ew = {4{wd[7:0]}};
    end else if (sz == 1) begin
      es = (a % 4 >= 2) ? 4'b1100 : 4'b0011;
      ew = {2{wd[15:0]}};
    end else begin
      es = 4'b1111;
      ew = wd;
    end
    memory_write = wr; memory_read = rd;
    ir_write = irw; lorD = lord; funct3 = f3;
    pc = pcv; alu_out = alu; wdata = wd;
    #1;
    chk("busy_idle_req", busy, 1);
    @(posedge clk); #1;
    if (mis) begin
      chk("mis_req", bus_req, 0);
      chk("mis_err", misalign_err, 1);
      chk("mis_busy", busy, 0);
      drop_req();
      @(posedge clk); #1;
      chk("mis_pulse", misalign_err, 0);
      chk("mis_ir", ir, exp_ir);
      chk("mis_mdr", mdr, exp_mdr);
      return;
    end
    chk("req", bus_req, 1);
    chk("addr", bus_addr, a & 32'hFFFF_FFFC);
    chk("we", bus_we, wr);
    chk("strb", bus_wstrb, wr ? es : 4'b0000);
    if (wr) chk("wdata", bus_wdata, ew);
    if (dly >= 0) begin
      repeat (dly) begin
        chk("req_wait", bus_req, 1);
        @(posedge clk); #1;
      end
      bus_ack = 1'b1; bus_rdata = rdv;
      @(posedge clk); #1;
      bus_ack = 1'b0;
      chk("done_req", bus_req, 0);
      chk("done_busy", busy, 0);
      chk("done_to", timeout_err, 0);
      if (!wr) begin
        if (irw && !lord) exp_ir = rdv;
        else exp_mdr = ref_load(f3, a, rdv);
      end
      chk("ir", ir, exp_ir);
      chk("mdr", mdr, exp_mdr);
      drop_req();
      @(posedge clk); #1;
      chk("idle_busy", busy, 0);
    end else begin
      n = 0;
      while (bus_req === 1'b1 && n < TO + 5) begin
        n++;
        @(posedge clk); #1;
      end
      chk("to_len", n, TO);
      chk("to_err", timeout_err, 1);
      drop_req();
      @(posedge clk); #1;
      chk("to_pulse", timeout_err, 0);
      chk("to_ir", ir, exp_ir);
      chk("to_mdr", mdr, exp_mdr);
    end
  endtask

  initial begin
    logic [2:0] f3s [8];
    f3s = '{3'b000, 3'b001, 3'b010, 3'b100,
            3'b101, 3'b011, 3'b110, 3'b111};
    #12;
    chk("rst_req", bus_req, 0);
    chk("rst_strb", bus_wstrb, 0);
    chk("rst_ir", ir, 0);
    chk("rst_mdr", mdr, 0);
    chk("rst_busy", busy, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    xact(0, 1, 1, 0, 3'b010, 32'h100, 0, 0, 32'h00500093, 0);
    xact(0, 1, 0, 1, 3'b000, 0, 32'h203, 0, 32'h80FFFFFF, 1);
    xact(0, 1, 0, 1, 3'b100, 0, 32'h203, 0, 32'h80FFFFFF, 0);
    xact(1, 0, 0, 1, 3'b001, 0, 32'h46, 32'h1234ABCD, 0, 2);
    xact(0, 1, 0, 1, 3'b010, 0, 32'h80, 0, 32'hDEAD, -1);
    xact(0, 1, 0, 1, 3'b010, 0, 32'h102, 0, 32'hCAFEF00D, 0);
    xact(1, 1, 0, 1, 3'b010, 0, 32'h300, 32'h55AA55AA, 32'h77, 0);

    // ack outside REQ is ignored
    bus_ack = 1'b1; bus_rdata = 32'hBADBAD00;
    @(posedge clk); #1;
    bus_ack = 1'b0;
    chk("idle_ack_req", bus_req, 0);
    chk("idle_ack_ir", ir, exp_ir);
    chk("idle_ack_mdr", mdr, exp_mdr);

    for (int i = 0; i < 60; i++) begin
      int k;
      int d;
      k = int'($urandom_range(0, 3));
      d = ($urandom_range(0, 7) == 0) ? -1 : int'($urandom_range(0, 3));
      case (k)
        0: xact(0, 1, 1'($urandom), 0, 3'b010, $urandom & 32'hFFFF_FFFC,
                $urandom, 0, $urandom, d);
        1: xact(0, 1, 1'($urandom), 1, f3s[$urandom_range(0, 7)], $urandom,
                $urandom, 0, $urandom, d);
        2: xact(1, 0, 0, 1, f3s[$urandom_range(0, 2)], $urandom,
                $urandom, $urandom, $urandom, d);
        default: xact(1, 1, 1'($urandom), 1, 3'b010, 0,
                      $urandom & 32'hFFFF_FFFC, $urandom, $urandom, d);
      endcase
    end

    // reset while a fetch is outstanding
    memory_read = 1'b1; ir_write = 1'b1; lorD = 1'b0;
    funct3 = 3'b010; pc = 32'h400;
    @(posedge clk); #1;
    chk("pre_rst_req", bus_req, 1);
    rst_n = 1'b0;
    #1;
    exp_ir = '0; exp_mdr = '0;
    chk("mid_rst_req", bus_req, 0);
    chk("mid_rst_ir", ir, 0);
    chk("mid_rst_mdr", mdr, 0);
    drop_req();
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    bus_ack = 1'b1; bus_rdata = 32'h12345678;
    @(posedge clk); #1;
    bus_ack = 1'b0;
    chk("post_rst_req", bus_req, 0);
    chk("post_rst_ir", ir, exp_ir);
    chk("post_rst_mdr", mdr, exp_mdr);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
